// File: rtl/gr_heep_pkg.sv
// Shared defaults for the external OBI crossbar and the arbiter that fronts it.
// Also holds the arbiter's state encoding so the bench and RTL agree on it.
package gr_heep_pkg;

    localparam int unsigned ExtXbarNMaster          = 2;
    localparam int unsigned LogExtXbarNMaster       = (ExtXbarNMaster > 1) ? $clog2(ExtXbarNMaster) : 1;
    localparam int unsigned ExtObiArbMaxOutstanding = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ext_obi_id_fifo.sv
// Small FIFO remembering which master owns each granted-but-unanswered transaction.
// Head is read combinationally so the response can be routed in the cycle it arrives.
module ext_obi_id_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]  count_reg;
    logic             push_ok, pop_ok;

    assign full    = (count_reg == CntW'(Depth));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty;
    assign rdata_o = mem[rd_ptr_reg];

    // Storage is never reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == PtrW'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == PtrW'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ext_obi_rr_arbiter.sv
// Round-robin arbiter merging several OBI masters onto one downstream OBI port,
// with in-order response routing back to the master that issued each request.
module ext_obi_rr_arbiter
    import gr_heep_pkg::*;
#(
    parameter int unsigned NMaster        = ExtXbarNMaster,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = ExtObiArbMaxOutstanding
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NMaster-1:0]              m_req_i,
    input  logic [NMaster-1:0]              m_we_i,
    input  logic [NMaster*AddrWidth-1:0]    m_addr_i,
    input  logic [NMaster*DataWidth-1:0]    m_wdata_i,
    input  logic [NMaster*DataWidth/8-1:0]  m_be_i,
    output logic [NMaster-1:0]              m_gnt_o,
    output logic [NMaster-1:0]              m_rvalid_o,
    output logic [DataWidth-1:0]            m_rdata_o,
    output logic                            s_req_o,
    output logic                            s_we_o,
    output logic [AddrWidth-1:0]            s_addr_o,
    output logic [DataWidth-1:0]            s_wdata_o,
    output logic [DataWidth/8-1:0]          s_be_o,
    input  logic                            s_gnt_i,
    input  logic                            s_rvalid_i,
    input  logic [DataWidth-1:0]            s_rdata_i,
    output logic [$clog2(MaxOutstanding):0] outstanding_o,
    output logic                            err_o
);

    localparam int unsigned IdW = (NMaster > 1) ? $clog2(NMaster) : 1;
    localparam int unsigned BeW = DataWidth / 8;

    arb_state_e       state_reg, state_next;
    logic [IdW-1:0]   rr_ptr_reg, sel_reg, sel_idle, sel, head_id, rot_off;
    logic [IdW:0]     sel_sum;
    logic [2*NMaster-1:0] req_rot;
    logic             any_req, gnt, pop, full, empty, err_reg;

    logic [AddrWidth-1:0] addr_arr  [NMaster];
    logic [DataWidth-1:0] wdata_arr [NMaster];
    logic [BeW-1:0]       be_arr    [NMaster];

    // Rotate requests so bit 0 is the master at rr_ptr, then take the lowest set bit.
    always_comb begin
        req_rot = {m_req_i, m_req_i} >> rr_ptr_reg;
        rot_off = '0;
        any_req = |m_req_i;
        for (int i = NMaster - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = IdW'(i);
            end
        end
        sel_sum = {1'b0, rr_ptr_reg} + {1'b0, rot_off};
        if (sel_sum >= (IdW + 1)'(NMaster)) begin
            sel_sum = sel_sum - (IdW + 1)'(NMaster);
        end
        sel_idle = sel_sum[IdW-1:0];
    end

    assign sel     = (state_reg == HOLD) ? sel_reg : sel_idle;
    assign s_req_o = ((state_reg == HOLD) | any_req) & ~full & ~rst_i;
    assign gnt     = s_req_o & s_gnt_i;
    assign pop     = s_rvalid_i & ~empty;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (s_req_o && !s_gnt_i) state_next = HOLD;
            HOLD:    if (gnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            sel_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel;
            if (gnt) begin
                rr_ptr_reg <= (sel == IdW'(NMaster - 1)) ? '0 : sel + 1'b1;
            end
            if (s_rvalid_i && empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NMaster; gi++) begin : g_master
            assign addr_arr[gi]    = m_addr_i[gi*AddrWidth +: AddrWidth];
            assign wdata_arr[gi]   = m_wdata_i[gi*DataWidth +: DataWidth];
            assign be_arr[gi]      = m_be_i[gi*BeW +: BeW];
            assign m_gnt_o[gi]     = gnt & (sel == IdW'(gi));
            assign m_rvalid_o[gi]  = pop & (head_id == IdW'(gi));
        end
    endgenerate

    assign s_we_o    = m_we_i[sel];
    assign s_addr_o  = addr_arr[sel];
    assign s_wdata_o = wdata_arr[sel];
    assign s_be_o    = be_arr[sel];
    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_reg;

    ext_obi_id_fifo #(
        .Width (IdW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt),
        .wdata_i (sel),
        .pop_i   (pop),
        .rdata_o (head_id),
        .full    (full),
        .empty   (empty),
        .count   (outstanding_o)
    );

endmodule

// File: doc/ext_obi_rr_arbiter.md
EXT_OBI_RR_ARBITER -- requirements
Module: ext_obi_rr_arbiter

Interface
REQ-001 SHALL have parameter NMaster, default 2, number of external OBI masters (legal range 1..16).
REQ-002 SHALL have parameter AddrWidth, default 32, OBI address width.
REQ-003 SHALL have parameter DataWidth, default 32, OBI data width; byte-enable width is DataWidth/8.
REQ-004 SHALL have parameter MaxOutstanding, default 4, response-tracking depth (power of two, 1..16).
REQ-005 SHALL have port clk_i, input, 1, single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1, reset; asynchronous assert, active-high.
REQ-007 SHALL have ports m_req_i, m_we_i, input, NMaster, per-master request and write-enable.
REQ-008 SHALL have ports m_addr_i, m_wdata_i, m_be_i, input, NMaster×AddrWidth, NMaster×DataWidth and NMaster×DataWidth/8, per-master payload.
REQ-009 SHALL have ports m_gnt_o, m_rvalid_o, output, NMaster, per-master grant and response-valid.
REQ-010 SHALL have port m_rdata_o, output, DataWidth, read data broadcast to all masters.
REQ-011 SHALL have ports s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o, output, matching widths, downstream OBI request.
REQ-012 SHALL have ports s_gnt_i, s_rvalid_i, input, 1, and s_rdata_i, input, DataWidth, downstream OBI response.
REQ-013 SHALL have port outstanding_o, output, $clog2(MaxOutstanding)+1, count of granted transactions not yet responded.
REQ-014 SHALL have port err_o, output, 1, sticky flag: rvalid received with no outstanding transaction.

Function
REQ-015 SHALL use a two-state FSM: IDLE (no pending downstream request) and HOLD (s_req_o asserted, not yet granted).
REQ-016 In IDLE, SHALL select the first requesting master scanning from rr_ptr upward, modulo NMaster.
REQ-017 SHALL assert s_req_o combinationally in the same cycle as the selected m_req_i, provided the tracker is not full.
REQ-018 When the tracker is full, SHALL hold s_req_o low and m_gnt_o all-zero, even if s_rvalid_i pops in that cycle.
REQ-019 SHALL drive the s_* payload from the selected master only; payload is don't-care while s_req_o is low.
REQ-020 In HOLD, SHALL keep the selection frozen until s_gnt_i, regardless of other requests.
REQ-021 SHALL assert m_gnt_o[k] = s_gnt_i & s_req_o & (sel==k); at most one grant bit per cycle.
REQ-022 On a grant to master k, SHALL set rr_ptr to (k+1) mod NMaster, push k into the tracker, and return to IDLE.
REQ-023 On s_req_o & !s_gnt_i, SHALL move to HOLD.
REQ-024 On s_rvalid_i with the tracker non-empty, SHALL pop the head index h, assert m_rvalid_o[h] in the same cycle, and pass s_rdata_i to m_rdata_o.
REQ-025 On s_rvalid_i with the tracker empty, SHALL assert no m_rvalid_o bit and set err_o; err_o clears only on reset.
REQ-026 On a simultaneous push and pop, SHALL keep outstanding_o unchanged and preserve FIFO order.
REQ-027 SHALL keep outstanding_o equal to pushes minus pops, never exceeding MaxOutstanding.
REQ-028 SHALL give a combinational request-to-grant latency of zero cycles.
REQ-029 SHALL support at most one downstream response per cycle.
REQ-030 With NMaster=1, SHALL degenerate to pass-through plus tracking, with rr_ptr constant 0.

Reset
REQ-031 On rst_i, SHALL asynchronously force FSM=IDLE, rr_ptr=0, tracker empty, outstanding_o=0, err_o=0, s_req_o=0, m_gnt_o=0, m_rvalid_o=0.
REQ-032 When reset is asserted mid-transaction, SHALL discard all outstanding IDs; later s_rvalid_i pulses follow REQ-025.

Structure
REQ-033 SHALL take its ExtXbarNMaster, ExtObiArbMaxOutstanding and LogExtXbarNMaster defaults from gr_heep_pkg; ExtObiArbMaxOutstanding (default 4) is added there.
REQ-034 SHALL implement the tracker as one sub-module, ext_obi_id_fifo, with width $clog2(NMaster) or 1, depth MaxOutstanding, and ports full/empty/count.

Verification
REQ-035 NMaster=2, both masters request continuously, s_gnt_i=1 -> grants alternate 0,1,0,1; rr_ptr starts at 0 after reset.
REQ-036 m0 requests, s_gnt_i low 3 cycles, m1 requests in cycle 1 -> m0 stays selected, payload stable, m0 granted in cycle 3, then m1.
REQ-037 MaxOutstanding=4, 4 grants with no rvalid -> outstanding_o=4, 5th request is not granted; one rvalid -> outstanding_o=3 and grant next cycle.
REQ-038 Grants in order m1,m0,m1; three rvalids with rdata 0xA,0xB,0xC -> m_rvalid_o pulses m1,m0,m1 with the matching data.
REQ-039 s_rvalid_i with outstanding_o=0 -> err_o=1 until rst_i, no m_rvalid_o bit set; same-cycle push+pop at count 2 -> count stays 2.
REQ-040 rst_i asserted in HOLD with 2 outstanding -> all outputs 0 immediately, FSM IDLE after release.
